// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel input conditioner.
//
// Contents:
//   SYNC_STAGES_DEF / DEBOUNCE_DEF : default synchronizer depth and filter length
//   cnt_width()                    : bits needed for the debounce counter
//   params_legal()                 : elaboration-time parameter range check
package sync_pkg;

  localparam int SYNC_STAGES_DEF = 3;
  localparam int DEBOUNCE_DEF    = 16;

  // The counter runs 0 .. cycles-1. The result is never below 1 bit, so a
  // counter declaration stays legal even for the smallest filter length.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  // Both the chain depth and the filter length need at least two cycles.
  function automatic bit params_legal(input int stages, input int cycles);
    return (stages >= 2) && (cycles >= 2);
  endfunction

endpackage

// File: rtl/sync_channel.sv
// One channel of the input conditioner: synchronizer chain, optional
// debounce counter, filtered level register and rise/fall pulse registers.
//
// Build option: define SYNC_DEBOUNCE_EN to build the debounce filter. When
// it is undefined, no counter is built, level follows sync_out one cycle
// later, and DEBOUNCE_CYCLES only takes part in the parameter check.
//
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   async_in in  raw asynchronous input
//   sync_out out last flop of the synchronizer chain (unfiltered)
//   level    out debounced level
//   rise     out one-cycle pulse on a 0->1 change of level
//   fall     out one-cycle pulse on a 1->0 change of level
module sync_channel
  import sync_pkg::*;
#(
  parameter int   STAGES          = SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic level,
  output logic rise,
  output logic fall
);

  if (!params_legal(STAGES, DEBOUNCE_CYCLES)) begin : g_param_check
    $error("sync_channel: STAGES and DEBOUNCE_CYCLES must both be >= 2");
  end

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{RESET_VAL}};
    else     chain <= {chain[STAGES-2:0], async_in};
  end

  assign sync_out = chain[STAGES-1];

  logic level_next;

`ifdef SYNC_DEBOUNCE_EN
  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // cnt counts consecutive cycles with sync_out != level. Any cycle where
  // they agree clears it, so a glitch restarts qualification. At the
  // terminal count the level is taken and the counter clears rather than
  // wrapping.
  always_comb begin
    level_next = level;
    cnt_next   = '0;
    if (sync_out != level) begin
      if (cnt == TERM) level_next = sync_out;
      else             cnt_next   = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end
`else
  assign level_next = sync_out;
`endif

  // Pulses are registered on the same edge as level, so they line up with
  // the first cycle of the new level. Reset clears them and reloads level
  // without comparing against its old value, so reset never makes a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= level_next;
      rise  <= level_next & ~level;
      fall  <= ~level_next & level;
    end
  end

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel input conditioner for asynchronous board-level signals.
// Each channel is an independent sync_channel instance; channels share
// only the clock and reset.
//
// Build option: SYNC_DEBOUNCE_EN enables the per-channel debounce filter
// (see sync_channel).
//
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   async_in in  [WIDTH] raw asynchronous inputs
//   sync_out out [WIDTH] synchronized, unfiltered inputs
//   level    out [WIDTH] debounced levels
//   rise     out [WIDTH] one-cycle pulses on 0->1 changes of level
//   fall     out [WIDTH] one-cycle pulses on 1->0 changes of level
module sync_debounce
  import sync_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               STAGES          = SYNC_STAGES_DEF,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_channel #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_VAL[i])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .async_in (async_in[i]),
      .sync_out (sync_out[i]),
      .level    (level[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench for sync_debounce (WIDTH=4, STAGES=3,
// DEBOUNCE_CYCLES=4, RESET_VAL=0). It runs directed scenarios followed by
// random input toggling, checked each cycle against a reference model.
// Reference rule: sync_out is the input as sampled STAGES edges earlier.
// A channel's level flips when the last DC_EFF sync_out values all differ
// from it. DC_EFF is DEBOUNCE_CYCLES with SYNC_DEBOUNCE_EN defined and 1
// without it.
module tb_sync_debounce;

  localparam int         W      = 4;
  localparam int         STAGES = 3;
  localparam int         DC     = 4;
  localparam logic [3:0] RV     = 4'h0;
`ifdef SYNC_DEBOUNCE_EN
  localparam int DC_EFF = DC;
`else
  localparam int DC_EFF = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] async_in = '0;
  logic [W-1:0] sync_out, level, rise, fall;

  sync_debounce #(
    .WIDTH(W), .STAGES(STAGES), .DEBOUNCE_CYCLES(DC), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst(rst), .async_in(async_in),
    .sync_out(sync_out), .level(level), .rise(rise), .fall(fall)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic [W-1:0] samp_q[$];
  logic [W-1:0] sync_hist[$];
  logic [W-1:0] m_sync, m_level, m_rise, m_fall;

  // scoreboard: expected level at each level-change event
  logic [W-1:0] exp_q[$];

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model from what the DUT sampled, then check
  // all outputs 1 time unit after the edge.
  task automatic tick();
    logic [W-1:0] in_s;
    logic         rst_s;
    logic [W-1:0] new_lvl;
    logic         all_diff;
    in_s  = async_in;
    rst_s = rst;
    @(posedge clk);
    if (rst_s) begin
      samp_q.delete();
      sync_hist.delete();
      for (int i = 0; i < STAGES; i++) samp_q.push_back(RV);
      for (int i = 0; i < DC_EFF; i++) sync_hist.push_back(RV);
      m_sync  = RV;
      m_level = RV;
      m_rise  = '0;
      m_fall  = '0;
    end else begin
      new_lvl = m_level;
      for (int c = 0; c < W; c++) begin
        all_diff = 1'b1;
        for (int i = 0; i < DC_EFF; i++)
          if (sync_hist[i][c] == m_level[c]) all_diff = 1'b0;
        if (all_diff) new_lvl[c] = ~m_level[c];
      end
      m_rise  = new_lvl & ~m_level;
      m_fall  = ~new_lvl & m_level;
      m_level = new_lvl;
      if ((m_rise | m_fall) != '0) exp_q.push_back(m_level);
      samp_q.push_back(in_s);
      void'(samp_q.pop_front());
      m_sync = samp_q[0];
      sync_hist.push_back(m_sync);
      void'(sync_hist.pop_front());
    end
    #1;
    chk("sync_out", sync_out, m_sync);
    chk("level", level, m_level);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("rise_and_fall", rise & fall, '0);
    if ((rise | fall) != '0) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", rise | fall, '0);
      else                   chk("event_level", level, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [W-1:0] v);
    async_in = v;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
  endtask

  int hold [W];

  initial begin
    // Reset with all inputs high, then count edges after release.
    drive(4'hF);
    apply_reset(2);
    chk("reset_level", level, 4'h0);
    chk("reset_sync", sync_out, 4'h0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == STAGES) chk("sync_at_edge_stages", sync_out, 4'hF);
      if (e == STAGES + DC_EFF - 1) chk("level_before_qual", level, 4'h0);
      if (e == STAGES + DC_EFF) begin
        chk("rise_at_qual_edge", rise, 4'hF);
        chk("level_at_qual_edge", level, 4'hF);
      end
      if (e == STAGES + DC_EFF + 1) chk("rise_one_cycle", rise, 4'h0);
    end

    // Glitch: channel 0 high for 3 cycles.
    drive(4'h0);
    apply_reset(2);
    drive(4'h1);
    ticks(3);
    drive(4'h0);
    ticks(10);

    // 1-cycle glitch on channel 2.
    drive(4'h4);
    ticks(1);
    drive(4'h0);
    ticks(10);

    // Clean toggle on channel 1.
    drive(4'h2);
    ticks(10);
    drive(4'h0);
    ticks(12);

    // Channel independence: 2 and 3 rise two cycles apart.
    drive(4'h4);
    ticks(2);
    drive(4'hC);
    ticks(12);
    drive(4'h0);
    ticks(12);

    // Reset while channel 1 is mid-qualification.
    drive(4'h2);
    ticks(STAGES + 2);
    apply_reset(1);
    ticks(12);
    drive(4'h0);
    ticks(12);

    // Random toggling with variable hold times and occasional resets.
    for (int c = 0; c < W; c++) hold[c] = $urandom_range(1, 8);
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < W; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          async_in[c] = ~async_in[c];
          hold[c] = $urandom_range(1, 9);
        end
      end
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    drive(4'h0);
    ticks(12);

    chk("missed_events", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
